// File: rtl/dense_accum_layer.sv
// Dense (fully connected) stage fed by the flattener. It counts per-pixel
// valid pulses and latches the vector once it is complete. Then it runs one
// MAC per cycle per neuron, and presents ReLU'd, shifted, saturated results
// through a valid/ready handshake.

// Per-neuron MAC lane: signed accumulator plus the output clamp.
module dense_accum_lane #(
  parameter int BitSize  = 2,
  parameter int AccW     = 9,
  parameter int OutShift = 0
) (
  input  logic               clk,
  input  logic               res,
  input  logic               clear,
  input  logic               en,
  input  logic               load,
  input  logic [BitSize-1:0] pix,
  input  logic [BitSize-1:0] wt,
  output logic [BitSize-1:0] out_data
);
  localparam logic signed [AccW-1:0] MaxV = AccW'((1 << BitSize) - 1);

  logic signed [AccW-1:0] acc, acc_next, pix_ext, wt_ext, prod, shifted;
  logic        [BitSize-1:0] sat;

  // Pixel is unsigned and the weight is two's complement. Both are widened
  // to the accumulator width before the multiply, so the product is exact.
  always_comb begin
    pix_ext  = {{(AccW-BitSize){1'b0}}, pix};
    wt_ext   = {{(AccW-BitSize){wt[BitSize-1]}}, wt};
    prod     = pix_ext * wt_ext;
    acc_next = acc + prod;
    shifted  = acc_next >>> OutShift;
    if (shifted[AccW-1])   sat = '0;
    else if (shifted > MaxV) sat = MaxV[BitSize-1:0];
    else                     sat = shifted[BitSize-1:0];
  end

  // Accumulator: cleared at vector capture, advanced every compute cycle.
  always_ff @(posedge clk) begin
    if (res)        acc <= '0;
    else if (clear) acc <= '0;
    else if (en)    acc <= acc_next;
  end

  // Result register: loaded from the final sum on the last compute edge.
  always_ff @(posedge clk) begin
    if (res)       out_data <= '0;
    else if (load) out_data <= sat;
  end
endmodule

module dense_accum_layer #(
  parameter int BitSize      = 2,
  parameter int InputSize    = 9,
  parameter int NumOfNeurons = 4,
  parameter int OutShift     = 0
) (
  input  logic                                               clk,
  input  logic                                               res,
  input  logic                                               in_valid,
  input  logic                                               in_start,
  input  logic [InputSize-1:0][BitSize-1:0]                  in_data,
  input  logic [NumOfNeurons-1:0][InputSize-1:0][BitSize-1:0] in_weights,
  output logic                                               in_ready,
  output logic                                               out_valid,
  input  logic                                               out_ready,
  output logic [NumOfNeurons-1:0][BitSize-1:0]               out_data,
  output logic                                               out_overrun
);
  localparam int AccW = 2*BitSize + $clog2(InputSize) + 1;
  localparam int CntW = $clog2(InputSize + 1);
  localparam int IdxW = (InputSize > 1) ? $clog2(InputSize) : 1;

  typedef enum logic [1:0] {S_COLLECT, S_COMPUTE, S_OUTPUT} state_t;
  state_t state, state_nxt;

  logic [CntW-1:0]                 pix_cnt, cnt_inc;
  logic [IdxW-1:0]                 elem_idx;
  logic [InputSize-1:0][BitSize-1:0] vec;
  logic                            take, capture, last;
  logic                            lane_clear, lane_en, lane_load;

  // A start pulse restarts the count at 1. Capture happens on the pulse
  // that brings the count to InputSize.
  always_comb begin
    take    = (state == S_COLLECT) && in_valid;
    cnt_inc = in_start ? CntW'(1) : pix_cnt + CntW'(1);
    capture = take && (cnt_inc == CntW'(InputSize));
    last    = (state == S_COMPUTE) && (elem_idx == IdxW'(InputSize - 1));
  end

  // State register.
  always_ff @(posedge clk) begin
    if (res) state <= S_COLLECT;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      S_COLLECT: if (capture)   state_nxt = S_COMPUTE;
      S_COMPUTE: if (last)      state_nxt = S_OUTPUT;
      S_OUTPUT:  if (out_ready) state_nxt = S_COLLECT;
      default:                  state_nxt = S_COLLECT;
    endcase
  end

  // State-decoded outputs and lane controls.
  always_comb begin
    in_ready   = (state == S_COLLECT);
    out_valid  = (state == S_OUTPUT);
    lane_clear = capture;
    lane_en    = (state == S_COMPUTE);
    lane_load  = last;
  end

  // Pixel counter, captured vector, element index and sticky overrun flag.
  always_ff @(posedge clk) begin
    if (res) begin
      pix_cnt     <= '0;
      vec         <= '0;
      elem_idx    <= '0;
      out_overrun <= 1'b0;
    end else begin
      if (in_valid && state != S_COLLECT) out_overrun <= 1'b1;
      if (capture) begin
        pix_cnt  <= '0;
        vec      <= in_data;
        elem_idx <= '0;
      end else begin
        if (take)    pix_cnt  <= cnt_inc;
        if (lane_en) elem_idx <= elem_idx + IdxW'(1);
      end
    end
  end

  for (genvar g = 0; g < NumOfNeurons; g++) begin : g_lane
    dense_accum_lane #(
      .BitSize (BitSize),
      .AccW    (AccW),
      .OutShift(OutShift)
    ) u_lane (
      .clk     (clk),
      .res     (res),
      .clear   (lane_clear),
      .en      (lane_en),
      .load    (lane_load),
      .pix     (vec[elem_idx]),
      .wt      (in_weights[g][elem_idx]),
      .out_data(out_data[g])
    );
  end
endmodule

// File: tb/tb_dense_accum_layer.sv
// Directed bench for dense_accum_layer. Two instances with InputSize=4 and
// two neurons share their stimulus: one has OutShift=0, the other OutShift=2.
module tb_dense_accum_layer;
  localparam int BS = 2, IS = 4, NN = 2;

  logic clk = 0, res = 0, in_valid = 0, in_start = 0, out_ready = 1;
  logic [IS-1:0][BS-1:0]         in_data = '0;
  logic [NN-1:0][IS-1:0][BS-1:0] in_weights = '0;
  logic in_ready, out_valid, out_overrun, in_ready2, out_valid2, out_overrun2;
  logic [NN-1:0][BS-1:0] out_data, out_data2;

  int pass = 0, total = 0;

  always #5 clk = ~clk;

  dense_accum_layer #(.BitSize(BS), .InputSize(IS), .NumOfNeurons(NN), .OutShift(0)) dut0 (
    .clk(clk), .res(res), .in_valid(in_valid), .in_start(in_start), .in_data(in_data),
    .in_weights(in_weights), .in_ready(in_ready), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_overrun(out_overrun));

  dense_accum_layer #(.BitSize(BS), .InputSize(IS), .NumOfNeurons(NN), .OutShift(2)) dut2 (
    .clk(clk), .res(res), .in_valid(in_valid), .in_start(in_start), .in_data(in_data),
    .in_weights(in_weights), .in_ready(in_ready2), .out_valid(out_valid2),
    .out_ready(out_ready), .out_data(out_data2), .out_overrun(out_overrun2));

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic pulse(input logic start);
    in_valid = 1; in_start = start; tick(); in_valid = 0; in_start = 0;
  endtask

  // data {1,1,0,0}; w0 {1,1,0,0}; w1 {1,0,0,0}
  task automatic load_basic();
    in_data = '0; in_data[0] = 2'd1; in_data[1] = 2'd1;
    in_weights = '0;
    in_weights[0][0] = 2'b01; in_weights[0][1] = 2'b01;
    in_weights[1][0] = 2'b01;
  endtask

  // data all 3; w0 all +1; w1 all -1
  task automatic load_sat();
    for (int k = 0; k < IS; k++) begin
      in_data[k] = 2'd3; in_weights[0][k] = 2'b01; in_weights[1][k] = 2'b11;
    end
  endtask

  // Four pulses, the first one marked as start; the last pulse is the capture edge.
  task automatic send_vec();
    for (int i = 0; i < IS; i++) pulse(i == 0);
  endtask

  task automatic test_reset();
    res = 1; tick(); tick(); res = 0;
    total++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid got=%0b exp=0", out_valid); else pass++;
    total++; if (in_ready !== 1'b1) $display("FAIL reset_in_ready got=%0b exp=1", in_ready); else pass++;
    total++; if (out_data !== 4'h0) $display("FAIL reset_out_data got=%h exp=0", out_data); else pass++;
    total++; if (out_overrun !== 1'b0) $display("FAIL reset_overrun got=%0b exp=0", out_overrun); else pass++;
  endtask

  task automatic test_basic_mac();
    load_basic(); out_ready = 1;
    send_vec();
    total++; if (in_ready !== 1'b0) $display("FAIL basic_busy in_ready got=%0b exp=0", in_ready); else pass++;
    for (int c = 0; c < IS - 1; c++) begin
      tick();
      total++; if (out_valid !== 1'b0) $display("FAIL basic_early_valid cyc=%0d got=%0b exp=0", c, out_valid); else pass++;
    end
    tick();
    total++; if (out_valid !== 1'b1) $display("FAIL basic_latency got=%0b exp=1", out_valid); else pass++;
    total++; if (out_data[0] !== 2'd2) $display("FAIL basic_n0 got=%0d exp=2", out_data[0]); else pass++;
    total++; if (out_data[1] !== 2'd1) $display("FAIL basic_n1 got=%0d exp=1", out_data[1]); else pass++;
    total++; if (out_data2 !== 4'h0) $display("FAIL shift2_basic got=%h exp=0", out_data2); else pass++;
    tick();
    total++; if (out_valid !== 1'b0) $display("FAIL basic_handshake out_valid got=%0b exp=0", out_valid); else pass++;
    total++; if (in_ready !== 1'b1) $display("FAIL basic_handshake in_ready got=%0b exp=1", in_ready); else pass++;
    total++; if (out_data[0] !== 2'd2) $display("FAIL basic_hold_after got=%0d exp=2", out_data[0]); else pass++;
  endtask

  task automatic test_saturation();
    load_sat(); out_ready = 1;
    send_vec();
    repeat (IS) tick();
    total++; if (out_valid !== 1'b1) $display("FAIL sat_valid got=%0b exp=1", out_valid); else pass++;
    total++; if (out_data[0] !== 2'd3) $display("FAIL sat_clip_high got=%0d exp=3", out_data[0]); else pass++;
    total++; if (out_data[1] !== 2'd0) $display("FAIL sat_relu got=%0d exp=0", out_data[1]); else pass++;
    total++; if (out_data2[0] !== 2'd3) $display("FAIL shift2_12 got=%0d exp=3", out_data2[0]); else pass++;
    total++; if (out_data2[1] !== 2'd0) $display("FAIL shift2_neg got=%0d exp=0", out_data2[1]); else pass++;
    tick();
  endtask

  task automatic test_backpressure();
    load_basic(); out_ready = 0;
    send_vec();
    repeat (IS) tick();
    total++; if (out_valid !== 1'b1) $display("FAIL bp_valid got=%0b exp=1", out_valid); else pass++;
    for (int c = 0; c < 10; c++) begin
      in_valid = (c == 2 || c == 5 || c == 7);
      tick();
      total++; if (out_valid !== 1'b1 || out_data !== {2'd1, 2'd2})
        $display("FAIL bp_hold cyc=%0d valid=%0b data=%h exp valid=1 data=6", c, out_valid, out_data);
      else pass++;
    end
    in_valid = 0;
    total++; if (in_ready !== 1'b0) $display("FAIL bp_in_ready got=%0b exp=0", in_ready); else pass++;
    total++; if (out_overrun !== 1'b1) $display("FAIL bp_overrun got=%0b exp=1", out_overrun); else pass++;
    total++; if (dut0.pix_cnt !== 3'd0) $display("FAIL bp_pix_cnt got=%0d exp=0", dut0.pix_cnt); else pass++;
    out_ready = 1; tick();
    total++; if (out_valid !== 1'b0) $display("FAIL bp_release_valid got=%0b exp=0", out_valid); else pass++;
    total++; if (in_ready !== 1'b1) $display("FAIL bp_release_ready got=%0b exp=1", in_ready); else pass++;
    total++; if (out_overrun !== 1'b1) $display("FAIL bp_sticky got=%0b exp=1", out_overrun); else pass++;
  endtask

  task automatic test_restart();
    load_sat(); out_ready = 1;
    pulse(1); pulse(0);
    // A start marker without valid must not touch the count.
    in_start = 1; tick(); in_start = 0;
    pulse(1);
    for (int i = 0; i < IS - 1; i++) begin
      total++; if (in_ready !== 1'b1) $display("FAIL restart_early_capture pulse=%0d got=%0b exp=1", i, in_ready); else pass++;
      pulse(0);
    end
    total++; if (in_ready !== 1'b0) $display("FAIL restart_capture got=%0b exp=0", in_ready); else pass++;
    repeat (IS) tick();
    total++; if (out_valid !== 1'b1 || out_data !== {2'd0, 2'd3})
      $display("FAIL restart_result valid=%0b data=%h exp valid=1 data=3", out_valid, out_data);
    else pass++;
    tick();
  endtask

  task automatic test_reset_compute();
    load_sat(); out_ready = 1;
    send_vec();
    tick(); tick();
    res = 1; tick(); res = 0;
    total++; if (out_valid !== 1'b0) $display("FAIL rstc_valid got=%0b exp=0", out_valid); else pass++;
    total++; if (in_ready !== 1'b1) $display("FAIL rstc_ready got=%0b exp=1", in_ready); else pass++;
    total++; if (out_data !== 4'h0) $display("FAIL rstc_data got=%h exp=0", out_data); else pass++;
    total++; if (out_overrun !== 1'b0) $display("FAIL rstc_overrun got=%0b exp=0", out_overrun); else pass++;
    repeat (IS) tick();
    total++; if (out_valid !== 1'b0) $display("FAIL rstc_no_stale_valid got=%0b exp=0", out_valid); else pass++;
    load_basic();
    send_vec();
    repeat (IS) tick();
    total++; if (out_valid !== 1'b1 || out_data !== {2'd1, 2'd2})
      $display("FAIL rstc_after valid=%0b data=%h exp valid=1 data=6", out_valid, out_data);
    else pass++;
    tick();
  endtask

  initial begin
    #1;
    test_reset();
    test_basic_mac();
    test_saturation();
    test_backpressure();
    test_restart();
    test_reset_compute();
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
